decode_ctrl_hazard: RTL and testbench

- Decode-stage control block of the 5-stage MIPS-subset pipeline.
- Takes the instruction held in the decode register and generates all datapath control signals, the 32-bit extended immediate and the write-register address.
- Resolves RAW hazards by forwarding from the E, M and W stages, and raises a load-use stall.
- Combinational except for an internal 3-entry shadow of destination registers (E, M, W).

---
 rtl/decode_ctrl_hazard.sv | 170 +++++++++++++++++
 tb/tb_decode_ctrl_hazard.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_hazard.sv
// Decode-stage control for the 5-stage MIPS-subset pipeline: control decode, immediate
// extension, E/M/W forwarding and load-use stall from a 3-entry destination shadow.
module decode_ctrl_hazard (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] inst,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] aluOutE,
    input  logic [31:0] memOutM,
    input  logic [31:0] rstW,
    output logic        regWe,
    output logic        dMemWe,
    output logic        sWRD,
    output logic        sA0,
    output logic        sA,
    output logic        sB,
    output logic        sByte,
    output logic [4:0]  aluOP,
    output logic [3:0]  brOP,
    output logic [4:0]  WRA,
    output logic [31:0] num,
    output logic [31:0] fwd1,
    output logic [31:0] fwd2,
    output logic        pause
);

    typedef struct packed {
        logic [4:0] wa;
        logic       we;
        logic       ld;
    } shadow_t;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        sign_ext;
    logic        is_load;
    logic        ld_use_rs;
    logic        ld_use_rt;
    shadow_t     e_q, m_q, w_q;
    shadow_t     e_d, m_d, w_d;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign funct = inst[5:0];

    always_comb begin
        regWe    = 1'b0;
        dMemWe   = 1'b0;
        sWRD     = 1'b0;
        sA0      = 1'b0;
        sA       = 1'b0;
        sB       = 1'b0;
        sByte    = 1'b0;
        aluOP    = 5'd0;
        brOP     = 4'd0;
        WRA      = 5'd0;
        sign_ext = 1'b0;
        is_load  = 1'b0;
        imm      = inst[15:0];
        case (op)
            6'h00: begin
                case (funct)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        regWe = 1'b1;
                        WRA   = rd;
                        case (funct)
                            6'h21:   aluOP = 5'd0;
                            6'h23:   aluOP = 5'd1;
                            6'h24:   aluOP = 5'd2;
                            6'h25:   aluOP = 5'd3;
                            6'h26:   aluOP = 5'd4;
                            6'h27:   aluOP = 5'd5;
                            6'h2A:   aluOP = 5'd6;
                            default: aluOP = 5'd7;
                        endcase
                    end
                    6'h00, 6'h02, 6'h03: begin
                        regWe = 1'b1;
                        sA    = 1'b1;
                        WRA   = rd;
                        imm   = {11'd0, inst[10:6]};
                        case (funct)
                            6'h00:   aluOP = 5'd8;
                            6'h02:   aluOP = 5'd9;
                            default: aluOP = 5'd10;
                        endcase
                    end
                    6'h08:   brOP = 4'd5;
                    default: ;
                endcase
            end
            6'h09: begin regWe = 1'b1; sB = 1'b1; WRA = rt; sign_ext = 1'b1; aluOP = 5'd0;  end
            6'h0A: begin regWe = 1'b1; sB = 1'b1; WRA = rt; sign_ext = 1'b1; aluOP = 5'd6;  end
            6'h0B: begin regWe = 1'b1; sB = 1'b1; WRA = rt; sign_ext = 1'b1; aluOP = 5'd7;  end
            6'h0C: begin regWe = 1'b1; sB = 1'b1; WRA = rt; aluOP = 5'd2;  end
            6'h0D: begin regWe = 1'b1; sB = 1'b1; WRA = rt; aluOP = 5'd3;  end
            6'h0E: begin regWe = 1'b1; sB = 1'b1; WRA = rt; aluOP = 5'd4;  end
            6'h0F: begin regWe = 1'b1; sB = 1'b1; WRA = rt; aluOP = 5'd11; end
            6'h23, 6'h20: begin
                regWe    = 1'b1;
                sWRD     = 1'b1;
                sB       = 1'b1;
                sign_ext = 1'b1;
                is_load  = 1'b1;
                sByte    = (op == 6'h20);
                WRA      = rt;
            end
            6'h2B, 6'h28: begin
                dMemWe   = 1'b1;
                sB       = 1'b1;
                sign_ext = 1'b1;
                sByte    = (op == 6'h28);
                WRA      = rt;
            end
            6'h04: begin brOP = 4'd1; sign_ext = 1'b1; end
            6'h05: begin brOP = 4'd2; sign_ext = 1'b1; end
            6'h02: brOP = 4'd3;
            6'h03: begin brOP = 4'd4; sA0 = 1'b1; regWe = 1'b1; WRA = 5'd31; end
            default: ;
        endcase
    end

    assign num = sign_ext ? {{16{imm[15]}}, imm} : {16'd0, imm};

    // Nearest producer wins; $0 is hard-wired so it is never forwarded.
    function automatic logic [31:0] fwd_sel(input logic [4:0] a, input logic [31:0] rf,
                                            input shadow_t e, input shadow_t m,
                                            input shadow_t w, input logic [31:0] e_val,
                                            input logic [31:0] m_val,
                                            input logic [31:0] w_val);
        if (a == 5'd0)                  return rf;
        else if (e.we && e.wa == a)     return e_val;
        else if (m.we && m.wa == a)     return m_val;
        else if (w.we && w.wa == a)     return w_val;
        else                            return rf;
    endfunction

    assign fwd1 = fwd_sel(rs, rd1, e_q, m_q, w_q, aluOutE, memOutM, rstW);
    assign fwd2 = fwd_sel(rt, rd2, e_q, m_q, w_q, aluOutE, memOutM, rstW);

    assign ld_use_rs = (rs != 5'd0) && e_q.we && e_q.ld && (e_q.wa == rs);
    assign ld_use_rt = (rt != 5'd0) && e_q.we && e_q.ld && (e_q.wa == rt);
    assign pause     = ld_use_rs || ld_use_rt;

    always_comb begin
        w_d = m_q;
        m_d = e_q;
        e_d = pause ? '0 : '{wa: WRA, we: regWe, ld: is_load};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_hazard.sv
// Self-checking bench: table-driven decode vectors plus hand-written forwarding,
// load-use stall and reset-during-stall sequences.
module tb_decode_ctrl_hazard;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] inst, rd1, rd2, aluOutE, memOutM, rstW;
    logic        regWe, dMemWe, sWRD, sA0, sA, sB, sByte, pause;
    logic [4:0]  aluOP, WRA;
    logic [3:0]  brOP;
    logic [31:0] num, fwd1, fwd2;

    int checks = 0;
    int failures = 0;

    decode_ctrl_hazard dut (
        .clk(clk), .rstn(rstn), .inst(inst), .rd1(rd1), .rd2(rd2),
        .aluOutE(aluOutE), .memOutM(memOutM), .rstW(rstW),
        .regWe(regWe), .dMemWe(dMemWe), .sWRD(sWRD), .sA0(sA0), .sA(sA), .sB(sB),
        .sByte(sByte), .aluOP(aluOP), .brOP(brOP), .WRA(WRA), .num(num),
        .fwd1(fwd1), .fwd2(fwd2), .pause(pause)
    );

    always #5 clk = ~clk;

    // ctl = {regWe,dMemWe,sWRD,sA0,sA,sB,sByte, aluOP, brOP, WRA}
    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [20:0] ctl;
        logic [31:0] num;
        bit          chk_wra;
        bit          chk_num;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [20:0] c(input logic [6:0] f, input logic [4:0] alu,
                                      input logic [3:0] br, input logic [4:0] wra);
        return {f, alu, br, wra};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
        tick();
    endtask

    task automatic add(input string n, input logic [31:0] i, input logic [20:0] ct,
                       input logic [31:0] nm, input bit cw, input bit cn);
        vec_t v;
        v.name = n; v.inst = i; v.ctl = ct; v.num = nm; v.chk_wra = cw; v.chk_num = cn;
        vecs.push_back(v);
    endtask

    initial begin
        logic [20:0] act_ctl, mask;
        rstn = 1'b0; inst = 32'h0; rd1 = 32'hAA; rd2 = 32'hBB;
        aluOutE = 32'h11; memOutM = 32'h22; rstW = 32'h33;

        add("sll0",   32'h0000_0000, c(7'b1000100, 5'd8,  4'd0, 5'd0),  32'h0,        1, 1);
        add("addiu",  32'h2422_FFFF, c(7'b1000010, 5'd0,  4'd0, 5'd2),  32'hFFFF_FFFF, 1, 1);
        add("ori",    32'h3403_8000, c(7'b1000010, 5'd3,  4'd0, 5'd3),  32'h0000_8000, 1, 1);
        add("jal",    32'h0C00_0100, c(7'b1001000, 5'd0,  4'd4, 5'd31), 32'h0,        1, 0);
        add("addu",   32'h0022_2021, c(7'b1000000, 5'd0,  4'd0, 5'd4),  32'h0,        1, 0);
        add("subu",   32'h00C7_2823, c(7'b1000000, 5'd1,  4'd0, 5'd5),  32'h0,        1, 0);
        add("sltu",   32'h0022_502B, c(7'b1000000, 5'd7,  4'd0, 5'd10), 32'h0,        1, 0);
        add("sra",    32'h0009_40C3, c(7'b1000100, 5'd10, 4'd0, 5'd8),  32'h3,        1, 1);
        add("jr",     32'h03E0_0008, c(7'b0000000, 5'd0,  4'd5, 5'd0),  32'h0,        0, 0);
        add("lw",     32'h8C25_FFFC, c(7'b1010010, 5'd0,  4'd0, 5'd5),  32'hFFFF_FFFC, 1, 1);
        add("lb",     32'h8046_0010, c(7'b1010011, 5'd0,  4'd0, 5'd6),  32'h10,       1, 1);
        add("sw",     32'hAC67_0008, c(7'b0100010, 5'd0,  4'd0, 5'd0),  32'h8,        0, 1);
        add("sb",     32'hA067_0008, c(7'b0100011, 5'd0,  4'd0, 5'd0),  32'h8,        0, 1);
        add("beq",    32'h1022_FFFF, c(7'b0000000, 5'd0,  4'd1, 5'd0),  32'hFFFF_FFFF, 0, 1);
        add("bne",    32'h1422_FFFF, c(7'b0000000, 5'd0,  4'd2, 5'd0),  32'hFFFF_FFFF, 0, 1);
        add("j",      32'h0800_0040, c(7'b0000000, 5'd0,  4'd3, 5'd0),  32'h0,        0, 0);
        add("lui",    32'h3C09_ABCD, c(7'b1000010, 5'd11, 4'd0, 5'd9),  32'h0000_ABCD, 1, 1);
        add("slti",   32'h2824_FFFE, c(7'b1000010, 5'd6,  4'd0, 5'd4),  32'hFFFF_FFFE, 1, 1);
        add("xori",   32'h3824_F0F0, c(7'b1000010, 5'd4,  4'd0, 5'd4),  32'h0000_F0F0, 1, 1);
        add("bad_op", 32'hFC00_0000, c(7'b0000000, 5'd0,  4'd0, 5'd0),  32'h0,        1, 0);
        add("bad_fn", 32'h0000_003F, c(7'b0000000, 5'd0,  4'd0, 5'd0),  32'h0,        1, 0);

        // Reset state with inst = 0
        #2;
        check("rst_pause", {31'd0, pause}, 32'd0);
        check("rst_fwd1", fwd1, 32'hAA);
        check("rst_fwd2", fwd2, 32'hBB);
        rstn = 1'b1;
        tick();

        foreach (vecs[k]) begin
            inst = vecs[k].inst;
            #1;
            act_ctl = {regWe, dMemWe, sWRD, sA0, sA, sB, sByte, aluOP, brOP, WRA};
            mask = vecs[k].chk_wra ? 21'h1F_FFFF : 21'h1F_FFE0;
            check({vecs[k].name, "_ctl"}, {11'd0, act_ctl & mask}, {11'd0, vecs[k].ctl & mask});
            if (vecs[k].chk_num) check({vecs[k].name, "_num"}, num, vecs[k].num);
            #2;
        end

        // E/M/W forwarding priority on rs
        do_reset();
        inst = 32'h0022_2021;                 // addu $4,$1,$2
        tick();
        inst = 32'h0080_3021;                 // addu $6,$4,$0
        #1;
        check("fwdE_rs", fwd1, 32'h11);
        check("fwdE_rt0", fwd2, 32'hBB);
        check("fwdE_pause", {31'd0, pause}, 32'd0);
        tick();
        check("fwdM_rs", fwd1, 32'h22);
        tick();
        check("fwdW_rs", fwd1, 32'h33);
        tick();
        check("fwd_none", fwd1, 32'hAA);

        // E forwarding on rt
        do_reset();
        inst = 32'h0022_2021;
        tick();
        inst = 32'h0004_3021;                 // addu $6,$0,$4
        #1;
        check("fwdE_rt", fwd2, 32'h11);

        // Writes to $0 never forwarded
        do_reset();
        inst = 32'h0022_0021;                 // addu $0,$1,$2
        tick();
        inst = 32'h0000_3021;                 // addu $6,$0,$0
        #1;
        check("zero_fwd1", fwd1, 32'hAA);
        check("zero_fwd2", fwd2, 32'hBB);

        // Load-use: one-cycle stall, then M forwarding
        do_reset();
        inst = 32'h8C25_FFFC;                 // lw $5
        tick();
        inst = 32'h00A0_3021;                 // addu $6,$5,$0
        #1;
        check("lu_pause1", {31'd0, pause}, 32'd1);
        tick();
        check("lu_pause2", {31'd0, pause}, 32'd0);
        check("lu_fwdM", fwd1, 32'h22);
        tick();
        check("lu_fwdW", fwd1, 32'h33);

        // Load-use through rt
        do_reset();
        inst = 32'h8C25_FFFC;
        tick();
        inst = 32'h0005_3021;                 // addu $6,$0,$5
        #1;
        check("lu_rt_pause", {31'd0, pause}, 32'd1);

        // Asynchronous reset during a stall
        #1;
        rstn = 1'b0;
        #1;
        check("rst_stall_pause", {31'd0, pause}, 32'd0);
        check("rst_stall_fwd2", fwd2, 32'hBB);
        rstn = 1'b1;
        tick();
        check("post_rst_pause", {31'd0, pause}, 32'd0);
        check("post_rst_fwd2", fwd2, 32'hBB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
